// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N byte-stream requesters.
// Frame locking keeps a multi-byte message contiguous on the wire.
module uart_tx_arbiter #(
  parameter int N            = 4,
  parameter int LOCK_FRAMES  = 1,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [7:0]     tx_data,
  output logic           tx_strobe,
  input  logic           tx_ready,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           lock_timeout,
  output logic           tx_fault
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);
  localparam int BW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TIMEOUT - 1);
  localparam logic [BW-1:0] BUSY_LAST = BW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_HOLD
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   owner_q;
  logic            locked_q;
  logic            last_q;
  logic [7:0]      tx_data_q;
  logic            strobe_q;
  logic [N-1:0]    req_ready_q;
  logic [N-1:0]    grant_q;
  logic [LW-1:0]   lock_cnt_q;
  logic [BW-1:0]   busy_cnt_q;
  logic            lock_timeout_q;
  logic            tx_fault_q;

  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   scan_idx;
  logic [PW-1:0]   sel_idx;
  logic [7:0]      sel_data;
  logic            sel_last;
  logic            own_valid;
  logic [PW-1:0]   next_ptr;

  function automatic logic [N-1:0] onehot(input logic [PW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First valid requester searching rr_ptr, rr_ptr+1, ... modulo N.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < N; i++) begin
      scan_idx = PW'((int'(rr_ptr_q) + i) % N);
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // While locked only the owner is eligible; otherwise the round-robin winner.
  always_comb begin
    sel_idx  = locked_q ? owner_q : win_idx;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel_idx == PW'(i)) begin
        sel_data = req_data[8*i +: 8];
        sel_last = req_last[i];
      end
    end
  end

  assign own_valid = req_valid[owner_q];
  assign next_ptr  = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      owner_q        <= '0;
      locked_q       <= 1'b0;
      last_q         <= 1'b0;
      tx_data_q      <= '0;
      strobe_q       <= 1'b0;
      req_ready_q    <= '0;
      grant_q        <= '0;
      lock_cnt_q     <= '0;
      busy_cnt_q     <= '0;
      lock_timeout_q <= 1'b0;
      tx_fault_q     <= 1'b0;
    end else begin
      strobe_q       <= 1'b0;
      req_ready_q    <= '0;
      lock_timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tx_ready && win_found) begin
            tx_data_q   <= sel_data;
            last_q      <= sel_last;
            owner_q     <= win_idx;
            grant_q     <= onehot(win_idx);
            strobe_q    <= 1'b1;
            req_ready_q <= onehot(win_idx);
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          busy_cnt_q <= '0;
          state_q    <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (!tx_ready) begin
            state_q <= S_WAIT_HIGH;
          end else if (busy_cnt_q == BUSY_LAST) begin
            tx_fault_q <= 1'b1;
            state_q    <= S_WAIT_HIGH;
          end else begin
            busy_cnt_q <= busy_cnt_q + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (tx_ready) begin
            if (LOCK_FRAMES != 0 && !last_q) begin
              locked_q   <= 1'b1;
              lock_cnt_q <= '0;
              state_q    <= S_HOLD;
            end else begin
              locked_q <= 1'b0;
              rr_ptr_q <= next_ptr;
              grant_q  <= '0;
              state_q  <= S_IDLE;
            end
          end
        end
        S_HOLD: begin
          if (own_valid) begin
            lock_cnt_q <= '0;
            if (tx_ready) begin
              tx_data_q   <= sel_data;
              last_q      <= sel_last;
              strobe_q    <= 1'b1;
              req_ready_q <= onehot(owner_q);
              state_q     <= S_ISSUE;
            end
          end else if (lock_cnt_q == LOCK_LAST) begin
            lock_timeout_q <= 1'b1;
            locked_q       <= 1'b0;
            rr_ptr_q       <= next_ptr;
            grant_q        <= '0;
            state_q        <= S_IDLE;
          end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign tx_data      = tx_data_q;
  assign tx_strobe    = strobe_q;
  assign grant        = grant_q;
  assign busy         = (state_q != S_IDLE);
  assign lock_timeout = lock_timeout_q;
  assign tx_fault     = tx_fault_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues, a uart_tx ready model,
// and expected wire bytes compared as each strobe appears.
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int LOCK_TO  = 20;
  localparam int BUSY_TO  = 4;
  localparam int BYTE_CYC = 6;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } item_t;

  typedef struct packed {
    logic [7:0]   data;
    logic [N-1:0] req;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_strobe;
  logic           tx_ready = 1'b1;
  logic [N-1:0]   grant;
  logic           busy;
  logic           lock_timeout;
  logic           tx_fault;

  item_t rq[N][$];
  exp_t  exp_q[$];
  logic  stuck = 1'b0;
  int    tx_cnt = 0;
  int    n_checks = 0;
  int    n_pass = 0;

  uart_tx_arbiter #(
    .N(N), .LOCK_FRAMES(1), .LOCK_TIMEOUT(LOCK_TO), .BUSY_TIMEOUT(BUSY_TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_data(tx_data), .tx_strobe(tx_strobe),
    .tx_ready(tx_ready), .grant(grant), .busy(busy),
    .lock_timeout(lock_timeout), .tx_fault(tx_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    item_t it;
    it.last = l;
    it.data = d;
    rq[r].push_back(it);
  endtask

  task automatic expect_byte(input logic [7:0] d, input int r);
    exp_t e;
    e.data = d;
    e.req  = '0;
    e.req[r] = 1'b1;
    exp_q.push_back(e);
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor, requesters and uart_tx ready model, all on the inactive edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (tx_strobe) begin
        check("strobe_when_ready", 32'(tx_ready), 1);
        check("exp_q_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(e.data));
          check("req_ready", 32'(req_ready), 32'(e.req));
          check("grant", 32'(grant), 32'(e.req));
        end
      end else begin
        check("req_ready_quiet", 32'(req_ready), 0);
      end
      for (int i = 0; i < N; i++)
        if (req_ready[i] && rq[i].size() != 0) void'(rq[i].pop_front());
    end
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() != 0) begin
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = rq[i][0].data;
        req_last[i]         = rq[i][0].last;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    if (stuck) begin
      tx_ready = 1'b1;
    end else if (tx_strobe && !reset) begin
      tx_ready = 1'b0;
      tx_cnt   = BYTE_CYC;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_ready = 1'b1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int cyc = 0;
    while ((exp_q.size() != 0 || busy || pending() || !tx_ready) && cyc < 500) begin
      tick();
      cyc++;
    end
    check({tag, "_drained"}, 32'(cyc < 500), 1);
    check({tag, "_idle_grant"}, 32'(grant), 0);
  endtask

  task automatic wait_exp(input string tag, input int left);
    int cyc = 0;
    while (exp_q.size() > left && cyc < 200) begin
      tick();
      cyc++;
    end
    check({tag, "_strobe_seen"}, 32'(cyc < 200), 1);
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_tx_strobe", 32'(tx_strobe), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_lock_timeout", 32'(lock_timeout), 0);
    check("rst_tx_fault", 32'(tx_fault), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Single byte: strobe and req_ready one cycle after valid.
    push(0, 8'h55, 1'b1);
    expect_byte(8'h55, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("t1_strobe", 32'(tx_strobe), 1);
    check("t1_req_ready", 32'(req_ready), 32'h1);
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_busy", 32'(busy), 1);
    @(posedge clk);
    #1;
    check("t1_strobe_one_cycle", 32'(tx_strobe), 0);
    check("t1_busy_wait", 32'(busy), 1);
    drain("t1");
    check("t1_busy_done", 32'(busy), 0);
    // rr_ptr now 1: requester 1 beats requester 0.
    push(0, 8'h60, 1'b1);
    push(1, 8'h61, 1'b1);
    expect_byte(8'h61, 1);
    expect_byte(8'h60, 0);
    drain("t1b");

    // Four simultaneous requesters from rr_ptr = 0.
    do_reset();
    for (int i = 0; i < N; i++) begin
      push(i, 8'hA0 + 8'(i), 1'b1);
      expect_byte(8'hA0 + 8'(i), i);
    end
    drain("t2");

    // Locked 3-byte frame from requester 2 while 1 and 3 wait.
    do_reset();
    push(1, 8'h10, 1'b1);
    expect_byte(8'h10, 1);
    drain("t3a");
    push(2, 8'h11, 1'b0);
    push(2, 8'h22, 1'b0);
    push(2, 8'h33, 1'b1);
    push(1, 8'h14, 1'b1);
    push(3, 8'h13, 1'b1);
    expect_byte(8'h11, 2);
    expect_byte(8'h22, 2);
    expect_byte(8'h33, 2);
    expect_byte(8'h13, 3);
    expect_byte(8'h14, 1);
    drain("t3");

    // Locked owner goes silent: forced release, next grant to owner+1.
    do_reset();
    push(0, 8'h70, 1'b0);
    push(1, 8'h71, 1'b1);
    push(2, 8'h72, 1'b1);
    expect_byte(8'h70, 0);
    expect_byte(8'h71, 1);
    expect_byte(8'h72, 2);
    wait_exp("t4", 2);
    cnt = 0;
    while (!tx_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    cnt = 0;
    while (!lock_timeout && cnt < 100) begin
      tick();
      cnt++;
      if (cnt < LOCK_TO) check("t4_hold_grant", 32'(grant), 32'h1);
    end
    check("t4_timeout_late_enough", 32'(cnt >= LOCK_TO), 1);
    check("t4_timeout_early_enough", 32'(cnt <= LOCK_TO + 3), 1);
    check("t4_release_grant", 32'(grant), 0);
    tick();
    check("t4_pulse_width", 32'(lock_timeout), 0);
    drain("t4");

    // tx_ready never falls: fault after BUSY_TIMEOUT, arbiter carries on.
    stuck = 1'b1;
    push(2, 8'h99, 1'b1);
    expect_byte(8'h99, 2);
    wait_exp("t5", 0);
    check("t5_fault_clear", 32'(tx_fault), 0);
    cnt = 0;
    while (!tx_fault && cnt < 50) begin
      tick();
      cnt++;
    end
    check("t5_fault_late_enough", 32'(cnt >= BUSY_TO), 1);
    check("t5_fault_early_enough", 32'(cnt <= BUSY_TO + 2), 1);
    push(3, 8'h9A, 1'b1);
    expect_byte(8'h9A, 3);
    drain("t5");
    check("t5_fault_sticky", 32'(tx_fault), 1);
    stuck = 1'b0;

    // Reset in WAIT_HIGH: async clear, then the byte is re-sent.
    do_reset();
    check("t6_fault_cleared", 32'(tx_fault), 0);
    push(1, 8'h5A, 1'b1);
    expect_byte(8'h5A, 1);
    wait_exp("t6", 0);
    repeat (2) tick();
    check("t6_busy_wait_high", 32'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_busy", 32'(busy), 0);
    check("t6_async_grant", 32'(grant), 0);
    check("t6_async_strobe", 32'(tx_strobe), 0);
    check("t6_async_req_ready", 32'(req_ready), 0);
    check("t6_async_tx_data", 32'(tx_data), 0);
    push(1, 8'h5A, 1'b1);
    expect_byte(8'h5A, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    drain("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
